alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be even and >=8.
REQ-002 Parameter ALU_CNTL_OP_W, default 4, internal ALU op-code width.
REQ-003 Parameter MD_EN, default 1, 1 = multiply/divide/HI-LO supported, 0 = those functs decode as illegal.
REQ-004 iClk  in  1  single clock; all state on rising edge.
REQ-005 iReset  in  1  asynchronous, active-high reset.
REQ-006 iValid  in  1  request valid.
REQ-007 oReady  out  1  unit accepts request this cycle.
REQ-008 iALUOp  in  2  00 add, 01 sub, 10 R-format by funct, 11 reserved.
REQ-009 iInstFunct  in  6  MIPS funct field.
REQ-010 iA, iB  in  DATA_W  operands (rs, rt).
REQ-011 oValid  out  1  result valid; held until iReady.
REQ-012 iReady  in  1  consumer accepts result.
REQ-013 oResult  out  DATA_W  result.
REQ-014 oZero  out  1  oResult == 0.
REQ-015 oOp  out  ALU_CNTL_OP_W  decoded op of the result in flight.
REQ-016 oIllegal  out  1  qualified by oValid; request was undecodable.
REQ-017 oHi, oLo  out  DATA_W  architectural HI/LO registers.
REQ-018 oBusy  out  1  multi-cycle operation in progress.

Function
REQ-019 Decode SHALL map: ALUOp 00->ADD(2), 01->SUB(6); ALUOp 10 with funct 0x20 ADD, 0x22 SUB, 0x24 AND(0), 0x25 OR(1), 0x26 XOR(3), 0x27 NOR(4), 0x2A SLT(7), 0x2B SLTU(5), 0x10 MFHI(8), 0x12 MFLO(9), 0x18 MULT(10), 0x19 MULTU(11), 0x1A DIV(12), 0x1B DIVU(13); anything else ILLEGAL(15).
REQ-020 Request accepted on iValid && oReady; oReady = (state==IDLE) && (!oValid || iReady).
REQ-021 Single-cycle ops: result registered, oValid asserted the cycle after acceptance (latency 1); back-to-back acceptance allowed when iReady=1.
REQ-022 ADD/SUB SHALL wrap modulo 2^DATA_W, no overflow trap; SLT signed, SLTU unsigned, result 0 or 1.
REQ-023 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on accepted MULT/MULTU, IDLE->DIV on accepted DIV/DIVU, MUL/DIV->DONE after DATA_W iterations, DONE->IDLE when result handed off (oValid && iReady).
REQ-024 MUL: shift-add, one bit per cycle, DATA_W cycles; {HI,LO} = full 2*DATA_W product; signed variant on magnitudes with final negate.
REQ-025 DIV: restoring, one quotient bit per cycle; LO = quotient, HI = remainder; signed: quotient truncates toward zero, remainder sign = dividend sign.
REQ-026 Divide by zero: no iteration; enter DONE next cycle; HI = iA, LO = all ones.
REQ-027 MULT/DIV result on oResult = new LO; oValid first asserted DATA_W+1 cycles after acceptance (2 for divide-by-zero).
REQ-028 HI/LO update exactly once, on MUL/DIV->DONE; oBusy=1 in MUL, DIV.
REQ-029 MFHI/MFLO return HI/LO, latency 1; never stale because only one request is in flight.
REQ-030 ILLEGAL: oValid with oIllegal=1, oResult=0, HI/LO unchanged; same for every MD op when MD_EN=0.
REQ-031 oResult/oOp/oIllegal stable while oValid && !iReady.
REQ-032 Requests with iValid=0 or while oReady=0 SHALL have no effect.

Reset
REQ-033 Reset SHALL force state IDLE, oValid 0, oResult 0, oOp ILLEGAL, oIllegal 0, oHi 0, oLo 0, oBusy 0; oReady 1 after release.
REQ-034 Reset mid-MUL/DIV aborts; partial product never reaches HI/LO.

Structure
REQ-035 Op-code constants, ALU_CNTL_OP_W and funct constants SHALL live in shared package alu_pkg, also used by the CPU decoder.
REQ-036 Iterative engine SHALL be sub-module alu_muldiv_seq (start, signed, mode, operands -> done, hi, lo); omitted when MD_EN=0.

Verification
REQ-037 ALUOp=10 funct 0x2A, A=0xFFFFFFFF, B=1 -> next cycle oValid, oResult=1, oOp=7; funct 0x2B same operands -> 0.
REQ-038 MULT A=0xFFFFFFFE (-2), B=3 -> oValid at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA, oBusy high cycles 1-32.
REQ-039 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> cycle 2, HI=7, LO=0xFFFFFFFF.
REQ-040 iReady held 0 for 5 cycles after ADD 5+7 -> oResult=12 stable, oReady=0, second request not taken until handoff.
REQ-041 iReset asserted at cycle 10 of MULTU -> oValid 0, HI=LO=0, next ADD accepted immediately after release.
REQ-042 ALUOp=11 or funct 0x3F -> oIllegal=1, oResult=0, HI/LO unchanged; MD_EN=0 build: MULT -> oIllegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings: op codes, MIPS funct values and the ALUOp/funct decoder.
// Used by both the execution unit and the CPU decoder so the encodings stay in one place.
package alu_pkg;

    localparam int unsigned ALU_CNTL_OP_W = 4;

    typedef logic [ALU_CNTL_OP_W-1:0] aluCntl_t;

    localparam aluCntl_t OpAnd     = 4'd0;
    localparam aluCntl_t OpOr      = 4'd1;
    localparam aluCntl_t OpAdd     = 4'd2;
    localparam aluCntl_t OpXor     = 4'd3;
    localparam aluCntl_t OpNor     = 4'd4;
    localparam aluCntl_t OpSltu    = 4'd5;
    localparam aluCntl_t OpSub     = 4'd6;
    localparam aluCntl_t OpSlt     = 4'd7;
    localparam aluCntl_t OpMfhi    = 4'd8;
    localparam aluCntl_t OpMflo    = 4'd9;
    localparam aluCntl_t OpMult    = 4'd10;
    localparam aluCntl_t OpMultu   = 4'd11;
    localparam aluCntl_t OpDiv     = 4'd12;
    localparam aluCntl_t OpDivu    = 4'd13;
    localparam aluCntl_t OpIllegal = 4'd15;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRType = 2'b10;

    localparam logic [5:0] FunctMfhi  = 6'h10;
    localparam logic [5:0] FunctMflo  = 6'h12;
    localparam logic [5:0] FunctMult  = 6'h18;
    localparam logic [5:0] FunctMultu = 6'h19;
    localparam logic [5:0] FunctDiv   = 6'h1A;
    localparam logic [5:0] FunctDivu  = 6'h1B;
    localparam logic [5:0] FunctAdd   = 6'h20;
    localparam logic [5:0] FunctSub   = 6'h22;
    localparam logic [5:0] FunctAnd   = 6'h24;
    localparam logic [5:0] FunctOr    = 6'h25;
    localparam logic [5:0] FunctXor   = 6'h26;
    localparam logic [5:0] FunctNor   = 6'h27;
    localparam logic [5:0] FunctSlt   = 6'h2A;
    localparam logic [5:0] FunctSltu  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} aluState_t;

    // HI/LO and multiply/divide functs fall back to illegal when the engine is absent.
    function automatic aluCntl_t decodeOp(input logic [1:0] aluOp, input logic [5:0] funct,
                                          input logic mdEn);
        aluCntl_t op;
        op = OpIllegal;
        case (aluOp)
            AluOpAdd: op = OpAdd;
            AluOpSub: op = OpSub;
            AluOpRType: begin
                case (funct)
                    FunctAdd:   op = OpAdd;
                    FunctSub:   op = OpSub;
                    FunctAnd:   op = OpAnd;
                    FunctOr:    op = OpOr;
                    FunctXor:   op = OpXor;
                    FunctNor:   op = OpNor;
                    FunctSlt:   op = OpSlt;
                    FunctSltu:  op = OpSltu;
                    FunctMfhi:  op = mdEn ? OpMfhi : OpIllegal;
                    FunctMflo:  op = mdEn ? OpMflo : OpIllegal;
                    FunctMult:  op = mdEn ? OpMult : OpIllegal;
                    FunctMultu: op = mdEn ? OpMultu : OpIllegal;
                    FunctDiv:   op = mdEn ? OpDiv : OpIllegal;
                    FunctDivu:  op = mdEn ? OpDivu : OpIllegal;
                    default:    op = OpIllegal;
                endcase
            end
            default: op = OpIllegal;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle.
// Signed operations run on magnitudes; sign fix-up is applied to the final outputs.
module alu_muldiv_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic              iSigned,
    input  logic              iMode,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic              oDone,
    output logic [DATA_W-1:0] oHi,
    output logic [DATA_W-1:0] oLo
);
    localparam int unsigned CntW = $clog2(DATA_W);

    logic              busyQ, modeQ, negResQ, negRemQ, divZeroQ;
    logic [CntW-1:0]   cntQ;
    logic [DATA_W-1:0] accQ, mplQ, mcdQ, aQ;
    logic [DATA_W-1:0] magA, magB, accD, mplD;
    logic [DATA_W:0]   sum, shifted;
    logic              geq;
    logic [2*DATA_W-1:0] prod, prodFinal;

    always_comb begin
        magA      = (iSigned && iA[DATA_W-1]) ? -iA : iA;
        magB      = (iSigned && iB[DATA_W-1]) ? -iB : iB;
        sum       = {1'b0, accQ} + (mplQ[0] ? {1'b0, mcdQ} : '0);
        shifted   = {accQ, mplQ[DATA_W-1]};
        geq       = shifted >= {1'b0, mcdQ};
        accD      = sum[DATA_W:1];
        mplD      = {sum[0], mplQ[DATA_W-1:1]};
        if (modeQ) begin
            // Difference is below the divisor, so DATA_W bits hold it exactly.
            accD = geq ? (shifted[DATA_W-1:0] - mcdQ) : shifted[DATA_W-1:0];
            mplD = {mplQ[DATA_W-2:0], geq};
        end
        prod      = {accD, mplD};
        prodFinal = negResQ ? -prod : prod;
        if (divZeroQ) begin
            oHi = aQ;
            oLo = '1;
        end else if (modeQ) begin
            oHi = negRemQ ? -accD : accD;
            oLo = negResQ ? -mplD : mplD;
        end else begin
            oHi = prodFinal[2*DATA_W-1:DATA_W];
            oLo = prodFinal[DATA_W-1:0];
        end
        oDone = busyQ && (divZeroQ || (cntQ == CntW'(DATA_W - 1)));
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            busyQ    <= 1'b0;
            modeQ    <= 1'b0;
            negResQ  <= 1'b0;
            negRemQ  <= 1'b0;
            divZeroQ <= 1'b0;
            cntQ     <= '0;
            accQ     <= '0;
            mplQ     <= '0;
            mcdQ     <= '0;
            aQ       <= '0;
        end else if (iStart) begin
            busyQ    <= 1'b1;
            modeQ    <= iMode;
            negResQ  <= iSigned && (iA[DATA_W-1] ^ iB[DATA_W-1]);
            negRemQ  <= iSigned && iA[DATA_W-1];
            divZeroQ <= iMode && (iB == '0);
            cntQ     <= '0;
            accQ     <= '0;
            mplQ     <= magA;
            mcdQ     <= magB;
            aQ       <= iA;
        end else if (busyQ) begin
            accQ <= accD;
            mplQ <= mplD;
            cntQ <= cntQ + 1'b1;
            if (oDone) begin
                busyQ <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake, single-cycle logic/arith ops and an
// optional iterative multiply/divide engine that owns the architectural HI/LO registers.
module alu_exec_unit #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ALU_CNTL_OP_W = alu_pkg::ALU_CNTL_OP_W,
    parameter bit          MD_EN         = 1'b1
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [1:0]               iALUOp,
    input  logic [5:0]               iInstFunct,
    input  logic [DATA_W-1:0]        iA,
    input  logic [DATA_W-1:0]        iB,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [DATA_W-1:0]        oResult,
    output logic                     oZero,
    output logic [ALU_CNTL_OP_W-1:0] oOp,
    output logic                     oIllegal,
    output logic [DATA_W-1:0]        oHi,
    output logic [DATA_W-1:0]        oLo,
    output logic                     oBusy
);
    import alu_pkg::*;

    aluState_t         stateQ, stateD;
    aluCntl_t          opDec, opQ;
    logic              accept, isMul, isDiv, mdStart, mdSigned, mdMode, mdDone;
    logic              validQ, illegalQ;
    logic [DATA_W-1:0] resultQ, hiQ, loQ, aluRes, mdHi, mdLo;

    always_comb begin
        opDec    = decodeOp(iALUOp, iInstFunct, MD_EN);
        isMul    = (opDec == OpMult) || (opDec == OpMultu);
        isDiv    = (opDec == OpDiv) || (opDec == OpDivu);
        oReady   = (stateQ == StIdle) && (!validQ || iReady);
        accept   = iValid && oReady;
        mdStart  = accept && (isMul || isDiv);
        mdSigned = (opDec == OpMult) || (opDec == OpDiv);
        mdMode   = isDiv;
    end

    always_comb begin
        aluRes = '0;
        case (opDec)
            OpAnd:  aluRes = iA & iB;
            OpOr:   aluRes = iA | iB;
            OpAdd:  aluRes = iA + iB;
            OpXor:  aluRes = iA ^ iB;
            OpNor:  aluRes = ~(iA | iB);
            OpSltu: aluRes = {{(DATA_W-1){1'b0}}, (iA < iB)};
            OpSub:  aluRes = iA - iB;
            OpSlt:  aluRes = {{(DATA_W-1){1'b0}}, ($signed(iA) < $signed(iB))};
            OpMfhi: aluRes = hiQ;
            OpMflo: aluRes = loQ;
            default: aluRes = '0;
        endcase
    end

    if (MD_EN) begin : gMd
        alu_muldiv_seq #(
            .DATA_W(DATA_W)
        ) uSeq (
            .iClk   (iClk),
            .iReset (iReset),
            .iStart (mdStart),
            .iSigned(mdSigned),
            .iMode  (mdMode),
            .iA     (iA),
            .iB     (iB),
            .oDone  (mdDone),
            .oHi    (mdHi),
            .oLo    (mdLo)
        );
    end else begin : gNoMd
        assign mdDone = 1'b0;
        assign mdHi   = '0;
        assign mdLo   = '0;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (accept && isMul) begin
                    stateD = StMul;
                end else if (accept && isDiv) begin
                    stateD = StDiv;
                end
            end
            StMul, StDiv: begin
                if (mdDone) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                if (validQ && iReady) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            stateQ   <= StIdle;
            validQ   <= 1'b0;
            resultQ  <= '0;
            opQ      <= OpIllegal;
            illegalQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                opQ      <= opDec;
                illegalQ <= (opDec == OpIllegal);
                // Multi-cycle ops drop valid until the engine finishes.
                validQ   <= !(isMul || isDiv);
                resultQ  <= aluRes;
            end else if (mdDone) begin
                validQ  <= 1'b1;
                resultQ <= mdLo;
                hiQ     <= mdHi;
                loQ     <= mdLo;
            end else if (validQ && iReady) begin
                validQ <= 1'b0;
            end
        end
    end

    assign oValid   = validQ;
    assign oResult  = resultQ;
    assign oZero    = (resultQ == '0);
    assign oOp      = ALU_CNTL_OP_W'(opQ);
    assign oIllegal = illegalQ;
    assign oHi      = hiQ;
    assign oLo      = loQ;
    assign oBusy    = (stateQ == StMul) || (stateQ == StDiv);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit, plus a second instance built without
// the multiply/divide engine.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0, ready = 1'b1;
    logic [1:0]  aluOp = 2'b00;
    logic [5:0]  funct = 6'h00;
    logic [31:0] a = '0, b = '0;
    logic        oReady, oValid, oZero, oIllegal, oBusy;
    logic [31:0] oResult, oHi, oLo;
    logic [3:0]  oOp;

    logic        valid0 = 1'b0, ready0 = 1'b1;
    logic [1:0]  aluOp0 = 2'b00;
    logic [5:0]  funct0 = 6'h00;
    logic [31:0] a0 = '0, b0 = '0;
    logic        oReady0, oValid0, oZero0, oIllegal0, oBusy0;
    logic [31:0] oResult0, oHi0, oLo0;
    logic [3:0]  oOp0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32), .ALU_CNTL_OP_W(4), .MD_EN(1'b1)) dut (
        .iClk(clk), .iReset(rst), .iValid(valid), .oReady(oReady), .iALUOp(aluOp),
        .iInstFunct(funct), .iA(a), .iB(b), .oValid(oValid), .iReady(ready),
        .oResult(oResult), .oZero(oZero), .oOp(oOp), .oIllegal(oIllegal), .oHi(oHi),
        .oLo(oLo), .oBusy(oBusy)
    );

    alu_exec_unit #(.DATA_W(32), .ALU_CNTL_OP_W(4), .MD_EN(1'b0)) dut0 (
        .iClk(clk), .iReset(rst), .iValid(valid0), .oReady(oReady0), .iALUOp(aluOp0),
        .iInstFunct(funct0), .iA(a0), .iB(b0), .oValid(oValid0), .iReady(ready0),
        .oResult(oResult0), .oZero(oZero0), .oOp(oOp0), .oIllegal(oIllegal0), .oHi(oHi0),
        .oLo(oLo0), .oBusy(oBusy0)
    );

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        valid = 1'b1; aluOp = op; funct = f; a = x; b = y;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Issues a multi-cycle op, returns the cycle oValid appeared (cycle 0 = acceptance).
    task automatic runMd(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         output int cyc, output logic [31:0] res, output logic [31:0] hi,
                         output logic [31:0] lo);
        issue(2'b10, f, x, y);
        cyc = 1;
        while (oValid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = oResult; hi = oHi; lo = oLo;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #10;
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", oValid); end
        checks++; if (oResult !== 32'h0) begin fails++; $display("FAIL rst_result: got %h want 0", oResult); end
        checks++; if (oOp !== 4'd15) begin fails++; $display("FAIL rst_op: got %0d want 15", oOp); end
        checks++; if (oIllegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b want 0", oIllegal); end
        checks++; if ({oHi, oLo} !== 64'h0) begin fails++; $display("FAIL rst_hilo: got %h want 0", {oHi, oLo}); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", oBusy); end
        checks++; if (oOp0 !== 4'd15) begin fails++; $display("FAIL rst_op_nomd: got %0d want 15", oOp0); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (oReady !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", oReady); end
    endtask

    task automatic test_slt;
        ready = 1'b1;
        issue(2'b10, 6'h2A, 32'hFFFFFFFF, 32'h1);
        checks++; if (oValid !== 1'b1) begin fails++; $display("FAIL slt_valid: got %b want 1", oValid); end
        checks++; if (oResult !== 32'h1) begin fails++; $display("FAIL slt_result: got %h want 1", oResult); end
        checks++; if (oOp !== 4'd7) begin fails++; $display("FAIL slt_op: got %0d want 7", oOp); end
        issue(2'b10, 6'h2B, 32'hFFFFFFFF, 32'h1);
        checks++; if (oResult !== 32'h0) begin fails++; $display("FAIL sltu_result: got %h want 0", oResult); end
        checks++; if (oOp !== 4'd5) begin fails++; $display("FAIL sltu_op: got %0d want 5", oOp); end
        checks++; if (oZero !== 1'b1) begin fails++; $display("FAIL sltu_zero: got %b want 1", oZero); end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [3:0]  code;
    } vec_t;

    task automatic test_back_to_back;
        vec_t vecs [11];
        vecs[0]  = '{2'b00, 6'h3F, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'd2};
        vecs[1]  = '{2'b01, 6'h00, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'd6};
        vecs[2]  = '{2'b10, 6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'd2};
        vecs[3]  = '{2'b10, 6'h22, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'd6};
        vecs[4]  = '{2'b10, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'd0};
        vecs[5]  = '{2'b10, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 4'd1};
        vecs[6]  = '{2'b10, 6'h26, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 4'd3};
        vecs[7]  = '{2'b10, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 4'd4};
        vecs[8]  = '{2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 4'd7};
        vecs[9]  = '{2'b10, 6'h2B, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 4'd5};
        vecs[10] = '{2'b10, 6'h2A, 32'h00000005, 32'hFFFFFFFF, 32'h00000000, 4'd7};
        ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            valid = 1'b1; aluOp = vecs[i].op; funct = vecs[i].f; a = vecs[i].x; b = vecs[i].y;
            @(posedge clk); #1;
            checks++; if (oValid !== 1'b1 || oResult !== vecs[i].r) begin fails++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, oValid, oResult, vecs[i].r); end
            checks++; if (oOp !== vecs[i].code) begin fails++; $display("FAIL b2b_op[%0d]: got %0d want %0d", i, oOp, vecs[i].code); end
            checks++; if (oReady !== 1'b1 || oIllegal !== 1'b0) begin fails++; $display("FAIL b2b_ready[%0d]: got rdy=%b ill=%b want 1 0", i, oReady, oIllegal); end
        end
        valid = 1'b0;
    endtask

    task automatic test_mult;
        ready = 1'b1;
        issue(2'b10, 6'h18, 32'hFFFFFFFE, 32'h3);
        for (int k = 1; k <= 32; k++) begin
            checks++; if ({oBusy, oValid} !== 2'b10) begin fails++; $display("FAIL mult_busy[cycle %0d]: got busy,valid=%b%b want 10", k, oBusy, oValid); end
            @(posedge clk); #1;
        end
        checks++; if (oValid !== 1'b1 || oBusy !== 1'b0) begin fails++; $display("FAIL mult_done33: got valid=%b busy=%b want 1 0", oValid, oBusy); end
        checks++; if (oResult !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_result: got %h want fffffffa", oResult); end
        checks++; if ({oHi, oLo} !== 64'hFFFFFFFF_FFFFFFFA) begin fails++; $display("FAIL mult_hilo: got %h want fffffffffffffffa", {oHi, oLo}); end
        checks++; if (oOp !== 4'd10) begin fails++; $display("FAIL mult_op: got %0d want 10", oOp); end
        checks++; if (oReady !== 1'b0) begin fails++; $display("FAIL mult_ready_done: got %b want 0", oReady); end
        @(posedge clk); #1;
        checks++; if (oReady !== 1'b1 || oValid !== 1'b0) begin fails++; $display("FAIL mult_handoff: got rdy=%b valid=%b want 1 0", oReady, oValid); end
    endtask

    task automatic test_mfhi_mflo;
        issue(2'b10, 6'h10, 32'h0, 32'h0);
        checks++; if (oResult !== 32'hFFFFFFFF || oOp !== 4'd8) begin fails++; $display("FAIL mfhi: got %h op %0d want ffffffff op 8", oResult, oOp); end
        issue(2'b10, 6'h12, 32'h0, 32'h0);
        checks++; if (oResult !== 32'hFFFFFFFA || oOp !== 4'd9) begin fails++; $display("FAIL mflo: got %h op %0d want fffffffa op 9", oResult, oOp); end
    endtask

    task automatic test_div;
        int cyc;
        logic [31:0] res, hi, lo;
        runMd(6'h1A, 32'hFFFFFFF9, 32'h2, cyc, res, hi, lo);
        checks++; if (cyc !== 33) begin fails++; $display("FAIL div_latency: got %0d want 33", cyc); end
        checks++; if ({hi, lo, res} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD}) begin fails++; $display("FAIL div_neg7_2: got hi=%h lo=%h res=%h want ffffffff fffffffd fffffffd", hi, lo, res); end
        runMd(6'h1B, 32'hFFFFFFFF, 32'h10, cyc, res, hi, lo);
        checks++; if ({hi, lo} !== {32'h0000000F, 32'h0FFFFFFF}) begin fails++; $display("FAIL divu_big: got hi=%h lo=%h want 0000000f 0fffffff", hi, lo); end
        runMd(6'h1A, 32'h80000000, 32'h3, cyc, res, hi, lo);
        checks++; if ({hi, lo} !== {32'hFFFFFFFE, 32'hD5555556}) begin fails++; $display("FAIL div_minint_3: got hi=%h lo=%h want fffffffe d5555556", hi, lo); end
        runMd(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, res, hi, lo);
        checks++; if ({hi, lo} !== {32'hFFFFFFFE, 32'h00000001}) begin fails++; $display("FAIL multu_max: got hi=%h lo=%h want fffffffe 00000001", hi, lo); end
        runMd(6'h1B, 32'h7, 32'h0, cyc, res, hi, lo);
        checks++; if (cyc !== 2) begin fails++; $display("FAIL divzero_latency: got %0d want 2", cyc); end
        checks++; if ({hi, lo, res} !== {32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin fails++; $display("FAIL divzero_vals: got hi=%h lo=%h res=%h want 7 ffffffff ffffffff", hi, lo, res); end
    endtask

    task automatic test_illegal;
        issue(2'b11, 6'h20, 32'h5, 32'h7);
        checks++; if (oValid !== 1'b1 || oIllegal !== 1'b1) begin fails++; $display("FAIL ill_aluop11: got valid=%b ill=%b want 1 1", oValid, oIllegal); end
        checks++; if (oResult !== 32'h0 || oOp !== 4'd15 || oZero !== 1'b1) begin fails++; $display("FAIL ill_aluop11_res: got %h op %0d z %b want 0 op 15 z 1", oResult, oOp, oZero); end
        checks++; if ({oHi, oLo} !== {32'h7, 32'hFFFFFFFF}) begin fails++; $display("FAIL ill_hilo: got %h want 00000007ffffffff", {oHi, oLo}); end
        issue(2'b10, 6'h3F, 32'h5, 32'h7);
        checks++; if (oIllegal !== 1'b1 || oResult !== 32'h0) begin fails++; $display("FAIL ill_funct3f: got ill=%b res=%h want 1 0", oIllegal, oResult); end
        issue(2'b00, 6'h3F, 32'h5, 32'h7);
        checks++; if (oIllegal !== 1'b0 || oResult !== 32'd12) begin fails++; $display("FAIL ill_clear: got ill=%b res=%h want 0 c", oIllegal, oResult); end
    endtask

    task automatic test_backpressure;
        ready = 1'b0;
        issue(2'b00, 6'h00, 32'd5, 32'd7);
        valid = 1'b1; aluOp = 2'b00; a = 32'd1; b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (oValid !== 1'b1 || oResult !== 32'd12 || oOp !== 4'd2) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b res=%h op %0d want 1 c 2", k, oValid, oResult, oOp); end
            checks++; if (oReady !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0", k, oReady); end
            @(posedge clk); #1;
        end
        ready = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        checks++; if (oValid !== 1'b1 || oResult !== 32'd2) begin fails++; $display("FAIL bp_second: got v=%b res=%h want 1 2", oValid, oResult); end
        @(posedge clk); #1;
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", oValid); end
    endtask

    task automatic test_reset_mid;
        ready = 1'b1;
        issue(2'b10, 6'h19, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (oBusy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b want 1", oBusy); end
        rst = 1'b1;
        #1;
        checks++; if (oValid !== 1'b0 || oBusy !== 1'b0) begin fails++; $display("FAIL rmid_abort: got v=%b busy=%b want 0 0", oValid, oBusy); end
        checks++; if ({oHi, oLo} !== 64'h0) begin fails++; $display("FAIL rmid_hilo: got %h want 0", {oHi, oLo}); end
        @(negedge clk) rst = 1'b0;
        issue(2'b00, 6'h00, 32'd2, 32'd3);
        checks++; if (oValid !== 1'b1 || oResult !== 32'd5) begin fails++; $display("FAIL rmid_add: got v=%b res=%h want 1 5", oValid, oResult); end
        repeat (40) begin @(posedge clk); #1; end
        checks++; if ({oHi, oLo} !== 64'h0 || oValid !== 1'b0) begin fails++; $display("FAIL rmid_no_partial: got hilo=%h v=%b want 0 0", {oHi, oLo}, oValid); end
    endtask

    task automatic test_md_disabled;
        valid0 = 1'b1; aluOp0 = 2'b10; funct0 = 6'h18; a0 = 32'hFFFFFFFE; b0 = 32'h3;
        @(posedge clk); #1;
        checks++; if (oValid0 !== 1'b1 || oIllegal0 !== 1'b1) begin fails++; $display("FAIL nomd_mult: got v=%b ill=%b want 1 1", oValid0, oIllegal0); end
        checks++; if (oResult0 !== 32'h0 || oOp0 !== 4'd15 || oBusy0 !== 1'b0) begin fails++; $display("FAIL nomd_mult_res: got %h op %0d busy %b want 0 15 0", oResult0, oOp0, oBusy0); end
        funct0 = 6'h10;
        @(posedge clk); #1;
        valid0 = 1'b0;
        checks++; if (oIllegal0 !== 1'b1 || {oHi0, oLo0} !== 64'h0) begin fails++; $display("FAIL nomd_mfhi: got ill=%b hilo=%h want 1 0", oIllegal0, {oHi0, oLo0}); end
    endtask

    initial begin
        test_reset;
        test_slt;
        test_back_to_back;
        test_mult;
        test_mfhi_mflo;
        test_div;
        test_illegal;
        test_backpressure;
        test_reset_mid;
        test_md_disabled;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
